// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module  : mem_access_pkg
// Brief   : Shared state encoding and default widths for mem_access_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

   localparam int c_def_addr_w      = 16;
   localparam int c_def_data_w      = 16;
   localparam int c_def_word_addr_w = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mac_lat_counter.sv
// ============================================================================
// Module  : mac_lat_counter
// Brief   : Loadable 2-bit down-counter with a done flag for the read wait.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_lat_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [1:0] load_val,
   input  logic       en,
   output logic       done
);

   logic [1:0] r_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 2'd0;
      end else if (load) begin
         r_count <= load_val;
      end else if (en && (r_count != 2'd0)) begin
         r_count <= r_count - 2'd1;
      end
   end

   assign done = (r_count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : Single-outstanding load/store initiator for the word data Memory.
//           Optional macro MAC_ALIGN_CHECK_EN rejects odd byte addresses.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W      = c_def_addr_w,
   parameter int DATA_W      = c_def_data_w,
   parameter int WORD_ADDR_W = c_def_word_addr_w,
   parameter int READ_LAT    = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);

   localparam logic [1:0] c_lat_load = 2'(READ_LAT - 1);

   state_t              r_state;
   state_t              w_next;
   state_t              w_new_state;
   logic                w_req_ready;
   logic                w_accept;
   logic                w_range_err;
   logic                w_align_err;
   logic                w_err;
   logic                w_lat_done;
   logic                w_rsp_valid;
   logic                w_mem_we;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic                r_rsp_err;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_din;

   // Any address bit above the word-select field means the word is out of range.
   assign w_range_err = |(req_addr >> (WORD_ADDR_W + 1));

`ifdef MAC_ALIGN_CHECK_EN
   assign w_align_err = req_addr[0];
`else
   assign w_align_err = 1'b0;
`endif

   assign w_err       = w_range_err | w_align_err;
   assign w_req_ready = reset_n & ((r_state == IDLE) | ((r_state == RESP) & rsp_ready));
   assign w_accept    = req_valid & w_req_ready;
   assign w_new_state = w_err ? RESP : (req_we ? WRITE : READ);

   mac_lat_counter u_lat_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (w_accept & ~w_err & ~req_we),
      .load_val (c_lat_load),
      .en       (r_state == READ),
      .done     (w_lat_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_rsp_valid = 1'b0;
      w_mem_we    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = w_new_state;
            end
         end
         WRITE: begin
            w_mem_we = 1'b1;
            w_next   = RESP;
         end
         READ: begin
            if (w_lat_done) begin
               w_next = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_next = w_accept ? w_new_state : IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Response fields are cleared on accept so stores and errors report zero data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mem_addr  <= '0;
         r_mem_din   <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_accept) begin
         r_mem_addr  <= req_addr;
         r_mem_din   <= req_wdata;
         r_rsp_rdata <= '0;
         r_rsp_err   <= w_err;
      end else if ((r_state == READ) && w_lat_done) begin
         r_rsp_rdata <= mem_dout;
      end
   end

   assign req_ready = w_req_ready;
   assign rsp_valid = w_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_addr  = r_mem_addr;
   assign mem_din   = r_mem_din;
   assign mem_we    = w_mem_we;
   assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Scoreboard bench for mem_access_ctrl with a behavioural Memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

   localparam int READ_LAT = 1;
`ifdef MAC_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } rsp_exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      int          acc;
   } wr_exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic        mem_we;
   logic [15:0] mem_dout;
   logic        busy;

   mem_access_ctrl #(
      .ADDR_W(16), .DATA_W(16), .WORD_ADDR_W(10), .READ_LAT(READ_LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_dout(mem_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory environment: asynchronous read, synchronous write.
   logic [15:0] mem [0:1023];
   int          wcnt [0:1023];
   logic [15:0] ref_mem [0:1023];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i] = '0;
         wcnt[i] = 0;
         ref_mem[i] = '0;
      end
   end

   assign mem_dout = mem[mem_addr[10:1]];

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[10:1]] <= mem_din;
         wcnt[mem_addr[10:1]] <= wcnt[mem_addr[10:1]] + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   rsp_exp_t rspq [$];
   wr_exp_t  wrq  [$];
   rsp_exp_t e_rsp;
   wr_exp_t  e_wr;
   bit       seen = 1'b0;
   int       first_cyc = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_we) begin
            if (wrq.size() == 0) begin
               check_eq("we_unexpected", 1, 0);
            end else begin
               e_wr = wrq.pop_front();
               check_eq("we_addr", mem_addr, e_wr.addr);
               check_eq("we_data", mem_din, e_wr.data);
               check_eq("we_lat", cyc - e_wr.acc, 1);
            end
         end
         if (rsp_valid) begin
            if (!seen) begin
               seen = 1'b1;
               first_cyc = cyc;
            end
            if (rspq.size() == 0) begin
               if (rsp_ready) check_eq("rsp_unexpected", 1, 0);
            end else if (rsp_ready) begin
               e_rsp = rspq.pop_front();
               check_eq("rsp_rdata", rsp_rdata, e_rsp.rdata);
               check_eq("rsp_err", rsp_err, e_rsp.err);
               check_eq("rsp_lat", first_cyc - e_rsp.acc, e_rsp.lat);
               seen = 1'b0;
            end else begin
               check_eq("hold_rdata", rsp_rdata, rspq[0].rdata);
               check_eq("hold_err", rsp_err, rspq[0].err);
               check_eq("hold_req_ready", req_ready, 0);
            end
         end
      end
   end

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                       output int acc);
      logic err;
      acc = -1;
      #1;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            acc = cyc;
            err = ((addr >> 11) != 0) || (ALIGN && addr[0]);
            if (!err && we) begin
               ref_mem[addr[10:1]] = wdata;
               wrq.push_back('{addr: addr, data: wdata, acc: acc});
            end
            rspq.push_back('{rdata: (err || we) ? 16'h0 : ref_mem[addr[10:1]],
                             err: err, acc: acc,
                             lat: err ? 1 : (we ? 2 : READ_LAT + 1)});
            @(posedge clk);
            return;
         end
         @(posedge clk);
      end
      check_eq("req_timeout", 0, 1);
   endtask

   task automatic idle();
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && rspq.size() != 0; i++) @(posedge clk);
      check_eq("drain", rspq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int a, a2, rise_cyc;
   int accs [4];
   logic [15:0] ra;

   initial begin
      // Reset state
      #12;
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_mem_we", mem_we, 0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_rsp_rdata", rsp_rdata, 0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      #1 check_eq("post_rst_ready", req_ready, 1);
      @(posedge clk);

      // Store then load
      send(1'b1, 16'h0010, 16'h1234, a);
      send(1'b0, 16'h0010, 16'h0000, a);
      idle();
      drain();

      // Out of range and misaligned
      @(posedge clk);
      send(1'b0, 16'h0800, 16'h0000, a);
      send(1'b1, 16'h0802, 16'hBEEF, a);
      send(1'b0, 16'h0011, 16'h0000, a);
      send(1'b0, 16'hFFFE, 16'h0000, a);
      idle();
      drain();

      // Back-to-back loads and throughput
      @(posedge clk);
      for (int i = 0; i < 4; i++) send(1'b1, 16'(2 * i), 16'hA000 + 16'(i), a);
      for (int i = 0; i < 4; i++) send(1'b0, 16'(2 * i), 16'h0000, accs[i]);
      idle();
      for (int i = 1; i < 4; i++) check_eq("thruput", accs[i] - accs[i-1], READ_LAT + 1);
      drain();

      // Response backpressure
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      fork
         begin
            send(1'b0, 16'h0002, 16'h0000, a);
            send(1'b0, 16'h0004, 16'h0000, a2);
            idle();
         end
         begin
            for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
            repeat (2) @(negedge clk);
            @(posedge clk);
            #1 rsp_ready = 1'b1;
            rise_cyc = cyc;
         end
      join
      check_eq("bp_accept_cyc", a2, rise_cyc);
      drain();

      // Random mix
      @(posedge clk);
      for (int i = 0; i < 12; i++) begin
         ra = 16'($urandom_range(0, 63));
         if (i % 4 == 3) ra = ra | 16'h1000;
         send(1'($urandom_range(0, 1)), ra, 16'($urandom), a);
      end
      idle();
      drain();

      // Reset during a write
      @(posedge clk);
      send(1'b1, 16'h0100, 16'h5A5A, a);
      idle();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst_we_drop", mem_we, 0);
      check_eq("rst_rsp_drop", rsp_valid, 0);
      rspq.delete();
      seen = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
      @(negedge clk);
      check_eq("rst2_req_ready", req_ready, 1);
      check_eq("rst2_busy", busy, 0);
      check_eq("wr_once", (wcnt[16'h0100 >> 1] <= 1), 1);
      repeat (3) @(posedge clk);
      check_eq("wrq_empty", wrq.size(), 0);
      check_eq("rspq_empty", rspq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule

`default_nettype wire
